// File: rtl/dcache_ctrl_pkg.sv
// Shared data-cache definitions: word/line geometry and controller state encodings.
package dcache_ctrl_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OFFSET_BITS = 2;
    localparam int LINE_WORDS  = 4;
    localparam int LINE_SIZE   = WORD_SIZE * LINE_WORDS;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [LINE_SIZE-1:0] line_t;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_FILL  = 2'd1,
        DC_WRITE = 2'd2,
        DC_RESP  = 2'd3
    } dc_state_e;

endpackage

// File: rtl/dcache_tag_array.sv
// Register-based valid/tag/data storage for the direct-mapped data cache.
// One lookup index serves the hit compare, the line fill and the single-word update.
module dcache_tag_array
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 2,
    localparam int TAG_W     = WORD_SIZE - INDEX_BITS - OFFSET_BITS,
    localparam int LINES     = 2 ** INDEX_BITS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [INDEX_BITS-1:0]  index,
    input  logic [TAG_W-1:0]       tag,
    input  logic [OFFSET_BITS-1:0] offset,
    output logic                   hit,
    output line_t                  line,
    input  logic                   fill_en,
    input  line_t                  fill_line,
    input  logic                   word_en,
    input  word_t                  word_data
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    line_t            data_q [LINES];
    line_t            data_d [LINES];

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[index] = 1'b1;
            tag_d[index]   = tag;
            data_d[index]  = fill_line;
        end
        if (word_en) begin
            data_d[index][int'(offset)*WORD_SIZE +: WORD_SIZE] = word_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    // NOTE: tag and data arrays carry no reset; the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit  = valid_q[index] && (tag_q[index] == tag);
    assign line = data_q[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with same-cycle hits.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [15:0]   cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic [15:0]   cpu_rdata,
    output logic          cpu_ready,
    output logic          is_hit,
    output logic          is_miss,
    output logic          mem_read,
    output logic          mem_write,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [63:0]   mem_rdata,
    input  logic          mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
`endif
);

    localparam int TAG_W = WORD_SIZE - INDEX_BITS - OFFSET_BITS;

    dc_state_e state_q, state_d;
    word_t     req_addr_q, req_addr_d;
    word_t     req_wdata_q, req_wdata_d;

    word_t                  lk_addr;
    logic                   lk_hit;
    line_t                  lk_line;
    word_t                  lk_word;
    logic                   fill_en;
    logic                   word_en;

    // Outside IDLE the array is addressed by the latched request, so CPU bus changes are ignored.
    assign lk_addr = (state_q == DC_IDLE) ? cpu_addr : req_addr_q;
    assign lk_word = lk_line[int'(lk_addr[OFFSET_BITS-1:0])*WORD_SIZE +: WORD_SIZE];
    assign fill_en = (state_q == DC_FILL) && mem_ack;
    assign word_en = (state_q == DC_WRITE) && mem_ack && lk_hit;

    dcache_tag_array #(.INDEX_BITS(INDEX_BITS)) u_tag_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .index     (lk_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS]),
        .tag       (lk_addr[WORD_SIZE-1:WORD_SIZE-TAG_W]),
        .offset    (lk_addr[OFFSET_BITS-1:0]),
        .hit       (lk_hit),
        .line      (lk_line),
        .fill_en   (fill_en),
        .fill_line (mem_rdata),
        .word_en   (word_en),
        .word_data (req_wdata_q)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DC_IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        case (state_q)
            DC_IDLE: begin
                if (cpu_write) begin
                    state_d     = DC_WRITE;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                end else if (cpu_read && !lk_hit) begin
                    state_d    = DC_FILL;
                    req_addr_d = cpu_addr;
                end
            end
            DC_FILL:  if (mem_ack) state_d = DC_RESP;
            DC_RESP:  state_d = DC_IDLE;
            DC_WRITE: if (mem_ack) state_d = DC_IDLE;
            default:  state_d = DC_IDLE;
        endcase
    end

    always_comb begin
        cpu_rdata = '0;
        cpu_ready = 1'b0;
        is_hit    = 1'b0;
        is_miss   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            DC_IDLE: begin
                if (cpu_write) begin
                    is_hit  = lk_hit;
                    is_miss = !lk_hit;
                end else if (cpu_read) begin
                    is_hit    = lk_hit;
                    is_miss   = !lk_hit;
                    cpu_ready = lk_hit;
                    cpu_rdata = lk_hit ? lk_word : '0;
                end
            end
            DC_FILL: begin
                mem_read = 1'b1;
                mem_addr = {req_addr_q[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            DC_RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = lk_word;
            end
            DC_WRITE: begin
                mem_write = 1'b1;
                mem_addr  = req_addr_q;
                mem_wdata = req_wdata_q;
                cpu_ready = mem_ack;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (is_hit && (hit_count_q != 16'hFFFF))   hit_count_d  = hit_count_q + 16'd1;
        if (is_miss && (miss_count_q != 16'hFFFF)) miss_count_d = miss_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random traffic
// checked against a line-level cache/memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, is_hit, is_miss;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    dcache_ctrl #(.INDEX_BITS(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .is_hit    (is_hit),
        .is_miss   (is_miss),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory, answering fills from whatever line address the cache presents.
    logic [15:0] mem [0:65535];
    assign mem_rdata = {mem[{mem_addr[15:2], 2'd3}], mem[{mem_addr[15:2], 2'd2}],
                        mem[{mem_addr[15:2], 2'd1}], mem[{mem_addr[15:2], 2'd0}]};

    // Reference cache contents: 4 lines, each valid/tag/4 words.
    bit          m_valid [4];
    logic [11:0] m_tag   [4];
    logic [15:0] m_data  [4][4];
    int          hits = 0;
    int          misses = 0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle(input bit spurious_ack);
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_ack   = spurious_ack;
        #1;
        check("idle_ready", 16'(cpu_ready), 16'd0);
        check("idle_pulse", 16'({is_hit, is_miss}), 16'd0);
        check("idle_memreq", 16'({mem_read, mem_write}), 16'd0);
    endtask

    task automatic access(input bit wr, input bit both, input logic [15:0] addr,
                          input logic [15:0] wd, input int delay);
        int          idx    = int'(addr[3:2]);
        int          off    = int'(addr[1:0]);
        logic [11:0] t      = addr[15:4];
        logic [15:0] line_a = {addr[15:2], 2'b00};
        bit          hit    = m_valid[idx] && (m_tag[idx] == t);
        @(negedge clk);
        mem_ack   = 1'b0;
        cpu_write = wr;
        cpu_read  = !wr || both;
        cpu_addr  = addr;
        cpu_wdata = wd;
        #1;
        check("pulse_hit", 16'(is_hit), 16'(hit));
        check("pulse_miss", 16'(is_miss), 16'(!hit));
        if (hit) hits++; else misses++;
        if (!wr && hit) begin
            check("hit_ready", 16'(cpu_ready), 16'd1);
            check("hit_rdata", cpu_rdata, m_data[idx][off]);
            check("hit_memreq", 16'({mem_read, mem_write}), 16'd0);
            return;
        end
        check("req_ready0", 16'(cpu_ready), 16'd0);
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            cpu_addr  = 16'($urandom);
            cpu_wdata = 16'($urandom);
            mem_ack   = (i == delay);
            #1;
            check("wait_pulse", 16'({is_hit, is_miss}), 16'd0);
            if (wr) begin
                check("wr_req", 16'({mem_read, mem_write}), 16'd1);
                check("wr_addr", mem_addr, addr);
                check("wr_data", mem_wdata, wd);
                check("wr_ready", 16'(cpu_ready), 16'(i == delay));
            end else begin
                check("fill_req", 16'({mem_read, mem_write}), 16'd2);
                check("fill_addr", mem_addr, line_a);
                check("fill_ready", 16'(cpu_ready), 16'd0);
            end
        end
        if (wr) begin
            mem[addr] = wd;
            if (hit) m_data[idx][off] = wd;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
            for (int k = 0; k < 4; k++) m_data[idx][k] = mem[line_a + 16'(k)];
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            check("resp_ready", 16'(cpu_ready), 16'd1);
            check("resp_rdata", cpu_rdata, m_data[idx][off]);
            check("resp_memreq", 16'({mem_read, mem_write}), 16'd0);
            check("resp_pulse", 16'({is_hit, is_miss}), 16'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a * 40503 + 17);
        mem[16'h0010] = 16'h0001;
        mem[16'h0011] = 16'h0002;
        mem[16'h0012] = 16'h0003;
        mem[16'h0013] = 16'h0004;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 16'(cpu_ready), 16'd0);
        check("rst_pulse", 16'({is_hit, is_miss}), 16'd0);
        check("rst_memreq", 16'({mem_read, mem_write}), 16'd0);
        check("rst_memaddr", mem_addr, 16'h0000);
        check("rst_memwdata", mem_wdata, 16'h0000);
        check("rst_rdata", cpu_rdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed scenarios.
        access(1'b0, 1'b0, 16'h0013, 16'h0000, 3);
        check("cold_read_value", m_data[0][3], 16'h0004);
        access(1'b0, 1'b0, 16'h0011, 16'h0000, 0);
        access(1'b1, 1'b0, 16'h0012, 16'hBEEF, 2);
        access(1'b0, 1'b0, 16'h0012, 16'h0000, 0);
        access(1'b1, 1'b0, 16'h0050, 16'h1234, 1);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
        access(1'b0, 1'b0, 16'h0030, 16'h0000, 2);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 1);
        access(1'b1, 1'b1, 16'h0011, 16'h5555, 0);
        access(1'b0, 1'b0, 16'h0011, 16'h0000, 0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Reset two cycles into a fill: request must drop at once and nothing stays valid.
        @(negedge clk);
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0023;
        mem_ack   = 1'b0;
        #1;
        check("rstfill_miss", 16'(is_miss), 16'd1);
        repeat (2) @(negedge clk);
        #1;
        check("rstfill_req", 16'(mem_read), 16'd1);
        #1;
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("rstfill_drop", 16'(mem_read), 16'd0);
        check("rstfill_ready", 16'(cpu_ready), 16'd0);
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        hits   = 0;
        misses = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        access(1'b0, 1'b0, 16'h0013, 16'h0000, 1);

        // Random traffic over a small address window to produce hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            bit          wr    = ($urandom_range(0, 2) == 0);
            bit          both  = wr && ($urandom_range(0, 1) == 1);
            logic [15:0] addr  = 16'($urandom_range(0, 63));
            logic [15:0] wd    = 16'($urandom);
            int          delay = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr[15:12] = 4'($urandom);
            access(wr, both, addr, wd, delay);
            if ($urandom_range(0, 5) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 16'(hits));
        check("miss_count", miss_count, 16'(misses));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
